// File: rtl/lcd_sched_pkg.sv
// Shared constants for the LCD command scheduler: FSM encoding, power-up
// command ROM, LCD command codes and the CPU control characters.
package lcd_sched_pkg;

    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WRAP = 2'd2;
    localparam logic [1:0] S_HOME = 2'd3;

    localparam logic [7:0] LCD_CLR   = 8'h01;
    localparam logic [7:0] LCD_LINE0 = 8'h80;
    localparam logic [7:0] LCD_LINE1 = 8'hC0;

    localparam logic [7:0] CH_NL = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;

    localparam int unsigned INIT_LEN = 5;
    localparam logic [8:0] INIT_CMD0 = 9'h038;
    localparam logic [8:0] INIT_CMD1 = 9'h00C;
    localparam logic [8:0] INIT_CMD2 = 9'h001;
    localparam logic [8:0] INIT_CMD3 = 9'h006;
    localparam logic [8:0] INIT_CMD4 = 9'h080;

    function automatic logic [8:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return INIT_CMD0;
            3'd1:    return INIT_CMD1;
            3'd2:    return INIT_CMD2;
            3'd3:    return INIT_CMD3;
            default: return INIT_CMD4;
        endcase
    endfunction

    // Address command for the line *other* than the current one.
    function automatic logic [8:0] next_line_cmd(input logic line);
        return {1'b0, line ? LCD_LINE0 : LCD_LINE1};
    endfunction

endpackage

// File: rtl/lcd_cmd_sched_if.sv
// CPU character port and LCDCONTROL handshake, bundled for the scheduler.
interface lcd_cmd_sched_if;
    logic       cpu_wen;
    logic [7:0] cpu_wdata;
    logic       cpu_wait;
    logic       lcd_status;
    logic       lcd_write;
    logic [8:0] lcd_wrdata;

    modport slave (
        input  cpu_wen, cpu_wdata, lcd_status,
        output cpu_wait, lcd_write, lcd_wrdata
    );

    modport master (
        output cpu_wen, cpu_wdata, lcd_status,
        input  cpu_wait, lcd_write, lcd_wrdata
    );
endinterface

// File: rtl/bf_sync_fifo.sv
// Synchronous show-ahead FIFO; head word is read straight from the storage
// registers so it is valid the cycle after it is written.
module bf_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];

    // A write while full is dropped even if a read frees a slot this cycle.
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_cmd_sched.sv
// LCD command scheduler: power-up sequence, character FIFO, and cursor
// address insertion for wrap, newline and form feed.
module lcd_cmd_sched
    import lcd_sched_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    parameter  int unsigned COLS  = 16,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    lcd_cmd_sched_if.slave    bus,
    output logic              init_busy,
    output logic [LW-1:0]     fifo_level
);

    localparam int unsigned CW = $clog2(COLS + 1);

    logic [1:0]    state;
    logic [2:0]    init_idx;
    logic          line;
    logic [CW-1:0] col;
    logic [CW-1:0] col_inc;
    logic [7:0]    head;
    logic          empty;
    logic          full;
    logic          ready;
    logic          pop;

    bf_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.cpu_wen),
        .wr_data (bus.cpu_wdata),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign bus.cpu_wait = full;

    // STATUS rises only the cycle after WRITE is seen, so our own pulse
    // must also block the following cycle.
    assign ready   = ~bus.lcd_status & ~bus.lcd_write;
    assign pop     = (state == S_RUN) & ready & ~empty;
    assign col_inc = col + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_INIT;
            init_idx       <= '0;
            init_busy      <= 1'b1;
            line           <= 1'b0;
            col            <= '0;
            bus.lcd_write  <= 1'b0;
            bus.lcd_wrdata <= '0;
        end else begin
            bus.lcd_write <= 1'b0;
            case (state)
                S_INIT: if (ready) begin
                    bus.lcd_write  <= 1'b1;
                    bus.lcd_wrdata <= init_cmd(init_idx);
                    if (init_idx == 3'(INIT_LEN - 1)) begin
                        init_idx  <= '0;
                        init_busy <= 1'b0;
                        state     <= S_RUN;
                    end else begin
                        init_idx <= init_idx + 1'b1;
                    end
                end
                S_RUN: if (pop) begin
                    bus.lcd_write <= 1'b1;
                    if (head == CH_NL) begin
                        bus.lcd_wrdata <= next_line_cmd(line);
                        line           <= ~line;
                        col            <= '0;
                    end else if (head == CH_FF) begin
                        bus.lcd_wrdata <= {1'b0, LCD_CLR};
                        state          <= S_HOME;
                    end else begin
                        bus.lcd_wrdata <= {1'b1, head};
                        col            <= col_inc;
                        if (col_inc == CW'(COLS))
                            state <= S_WRAP;
                    end
                end
                S_WRAP: if (ready) begin
                    bus.lcd_write  <= 1'b1;
                    bus.lcd_wrdata <= next_line_cmd(line);
                    line           <= ~line;
                    col            <= '0;
                    state          <= S_RUN;
                end
                default: if (ready) begin
                    bus.lcd_write  <= 1'b1;
                    bus.lcd_wrdata <= {1'b0, LCD_LINE0};
                    line           <= 1'b0;
                    col            <= '0;
                    state          <= S_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Directed and randomized bench for lcd_cmd_sched against a word-level
// model of the expected LCD command/data stream.
module tb_lcd_cmd_sched;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned COLS  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_busy;
    logic [5:0] fifo_level;

    lcd_cmd_sched_if bus();

    lcd_cmd_sched #(
        .DEPTH (DEPTH),
        .COLS  (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .init_busy  (init_busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [8:0]  obs[$];
    int unsigned obs_cyc[$];
    logic        obs_busy[$];
    int unsigned last_pulse = 0;
    bit          seen_pulse = 1'b0;

    logic [8:0]  exp_q[$];
    int          mline;
    int          mcol;

    // Pulse monitor: records every write and checks minimum spacing.
    always @(negedge clk) begin
        if (bus.lcd_write === 1'b1) begin
            if (seen_pulse) begin
                checks++;
                assert ((cyc - last_pulse) >= 2)
                else begin
                    errors++;
                    $error("FAIL spacing obs=%0d exp>=2", cyc - last_pulse);
                end
            end
            seen_pulse = 1'b1;
            last_pulse = cyc;
            obs.push_back(bus.lcd_wrdata);
            obs_cyc.push_back(cyc);
            obs_busy.push_back(init_busy);
        end
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e)
        else begin
            errors++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, o, e);
        end
    endtask

    task automatic model_init();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h080);
        mline = 0;
        mcol  = 0;
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c == 8'h0A) begin
            exp_q.push_back(mline == 0 ? 9'h0C0 : 9'h080);
            mline = 1 - mline;
            mcol  = 0;
        end else if (c == 8'h0C) begin
            exp_q.push_back(9'h001);
            exp_q.push_back(9'h080);
            mline = 0;
            mcol  = 0;
        end else begin
            exp_q.push_back({1'b1, c});
            mcol++;
            if (mcol == COLS) begin
                exp_q.push_back(mline == 0 ? 9'h0C0 : 9'h080);
                mline = 1 - mline;
                mcol  = 0;
            end
        end
    endtask

    task automatic push(input logic [7:0] c);
        bus.cpu_wen   = 1'b1;
        bus.cpu_wdata = c;
        @(posedge clk);
        #1;
        bus.cpu_wen   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int budget);
        int n = 0;
        while (obs.size() < exp_q.size() && n < budget) begin
            @(posedge clk);
            n++;
        end
        idle(6);
    endtask

    task automatic compare_obs(input string tag);
        chk({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), obs[i], exp_q[i]);
        obs.delete();
        obs_cyc.delete();
        obs_busy.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned k;
        int          npush;
        logic [7:0]  c;

        rst            = 1'b1;
        bus.cpu_wen    = 1'b0;
        bus.cpu_wdata  = '0;
        bus.lcd_status = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_write",  bus.lcd_write,  1'b0);
        chk("rst_wrdata", bus.lcd_wrdata, 9'h000);
        chk("rst_wait",   bus.cpu_wait,   1'b0);
        chk("rst_busy",   init_busy,      1'b1);
        chk("rst_level",  fifo_level,     6'd0);

        // Power-up sequence
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_init();
        wait_obs(100);
        chk("init_busy_p4", obs_busy[3], 1'b1);
        chk("init_busy_p5", obs_busy[4], 1'b0);
        chk("init_span",    obs_cyc[4] - obs_cyc[0], 8);
        compare_obs("init");
        chk("init_done", init_busy, 1'b0);
        chk("wrdata_hold", bus.lcd_wrdata, 9'h080);

        // Single character latency
        push(8'h41);
        k = cyc;
        model_char(8'h41);
        wait_obs(50);
        chk("lat_A", obs_cyc[0], k + 1);
        compare_obs("charA");
        chk("level_A", fifo_level, 6'd0);

        // 17 characters across the line wrap
        for (int i = 0; i < 17; i++) begin
            push(8'h30 + 8'(i));
            model_char(8'h30 + 8'(i));
        end
        wait_obs(200);
        compare_obs("wrap");

        // Form feed and newlines
        push(8'h0C); model_char(8'h0C);
        push(8'h0A); model_char(8'h0A);
        push(8'h0A); model_char(8'h0A);
        push(8'h0C); model_char(8'h0C);
        wait_obs(100);
        compare_obs("ctrl");

        // Random characters with random controller busy
        npush = 0;
        for (int i = 0; i < 60; i++) begin
            bus.lcd_status = ($urandom_range(0, 2) == 0);
            if (npush < 30 && $urandom_range(0, 1) == 1) begin
                c = 8'($urandom_range(32, 126));
                case ($urandom_range(0, 7))
                    0:       c = 8'h0A;
                    1:       c = 8'h0C;
                    default: c = c;
                endcase
                push(c);
                model_char(c);
                npush++;
            end else begin
                idle(1);
            end
        end
        bus.lcd_status = 1'b0;
        wait_obs(400);
        compare_obs("rand");

        // Overflow with the controller held busy
        bus.lcd_status = 1'b1;
        for (int i = 0; i < 31; i++) begin
            push(8'h50 + 8'(i));
            model_char(8'h50 + 8'(i));
        end
        chk("wait_31",  bus.cpu_wait, 1'b0);
        chk("level_31", fifo_level,   6'd31);
        push(8'h6F);
        model_char(8'h6F);
        chk("wait_32",  bus.cpu_wait, 1'b1);
        chk("level_32", fifo_level,   6'd32);
        push(8'h70);
        chk("level_33", fifo_level,   6'd32);
        idle(1);
        bus.lcd_status = 1'b0;
        wait_obs(400);
        compare_obs("full");
        chk("level_drained", fifo_level, 6'd0);

        // Reset with characters queued
        bus.lcd_status = 1'b1;
        for (int i = 0; i < 10; i++)
            push(8'h61 + 8'(i));
        chk("level_10", fifo_level, 6'd10);
        rst = 1'b1;
        idle(1);
        chk("mid_rst_level", fifo_level, 6'd0);
        chk("mid_rst_busy",  init_busy,  1'b1);
        rst            = 1'b0;
        bus.lcd_status = 1'b0;
        model_init();
        wait_obs(100);
        idle(40);
        compare_obs("rerst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_sched.md
# lcd_cmd_sched

Command scheduler between the brainfuck core's character output port and the LCD controller (`LCDCONTROL`). It runs the LCD power-up command sequence and buffers CPU characters in a FIFO. It issues one command or data word at a time under the controller's STATUS handshake, and inserts cursor-address commands for line wrap, newline and form feed.

## Interface
Parameters:
- `DEPTH`, 32: character FIFO entries (power of two, 4..64).
- `COLS`, 16: visible columns per LCD line.

Ports:
- `clk` in, 1: system clock.
- `rst` in, 1: synchronous, active-high reset.
- `cpu_wen` in, 1: CPU character write strobe, one word per cycle.
- `cpu_wdata` in, 8: character byte.
- `cpu_wait` out, 1: FIFO full; the CPU must hold its write while this is high.
- `lcd_status` in, 1: controller busy (STATUS).
- `lcd_write` out, 1: one-cycle write pulse to the controller.
- `lcd_wrdata` out, 9: bit 8 = RS (0 command, 1 data), bits 7:0 = byte.
- `init_busy` out, 1: high until the power-up sequence has been issued.
- `fifo_level` out, $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Reset values: `lcd_write`=0, `lcd_wrdata`=0, `cpu_wait`=0, `init_busy`=1, `fifo_level`=0; FIFO empty; FSM=S_INIT (index 0); line=0, col=0.
- Issue condition: `ready = !lcd_status & !lcd_write`. Exactly one word is issued per ready cycle, and only in a ready cycle.
- **S_INIT**: issues 0x038, 0x00C, 0x001, 0x006, 0x080 in order, one per ready cycle. After the fifth word, `init_busy` drops and the FSM goes to S_RUN. CPU pushes are accepted during init.
- **S_RUN**: when ready and the FIFO is non-empty, pop the head and act on it:
  - 0x0A (newline): issue command 0x0C0 if line=0, else 0x080. Toggle line, set col=0.
  - 0x0C (form feed): issue 0x001, go to S_HOME.
  - Any other byte: issue {1'b1, byte}, col+1. If col reaches COLS, go to S_WRAP.
- **S_WRAP**: when ready, issue the next-line address (0x0C0 if line=0, else 0x080), toggle line, set col=0, return to S_RUN. No pop occurs in this state.
- **S_HOME**: when ready, issue 0x080, set line=0 and col=0, return to S_RUN.
- FIFO push: accepted when `cpu_wen & !cpu_wait`. A push while full is dropped, even if a pop happens the same cycle.
- Simultaneous push and pop when not full: both take effect and the level is unchanged.
- Empty FIFO in S_RUN: no output; the FSM holds.
- Line wrap from line 1 returns to line 0 at 0x080. The display overwrites; it does not scroll.

## Timing
- `lcd_write` and `lcd_wrdata` are registered. `lcd_wrdata` holds its value until the next issue.
- `cpu_wait` is combinational from the level: `fifo_level == DEPTH`.
- Latency: a character pushed at edge k, with S_RUN idle and ready at k+1, produces `lcd_write`=1 during the cycle following edge k+1.
- Minimum spacing between pulses is 2 cycles: the cycle after a pulse is never ready.
- `lcd_status` is sampled only in the issue decision. The controller raises it in the cycle after it samples WRITE.
- Reset asserted mid-operation: all state returns to reset values at the next edge. The FIFO is flushed, any in-flight wrap or home is dropped, and init restarts.

## Structure
- Shared package `lcd_sched_pkg` holds:
  - state encoding (S_INIT, S_RUN, S_WRAP, S_HOME);
  - init command ROM constants (5 × 9 bit);
  - LCD codes LCD_CLR=0x01, LCD_LINE0=0x80, LCD_LINE1=0xC0;
  - control bytes CH_NL=0x0A, CH_FF=0x0C.
- One sub-module, `bf_sync_fifo`:
  - parameterised width and depth;
  - synchronous reset, registered head output, level output;
  - write ignored when full.
  - It is reused later for the key-input path.

## Test plan
- Reset, `lcd_status` tied 0 → pulses carry 0x038, 0x00C, 0x001, 0x006, 0x080 on every second cycle; `init_busy` falls after the fifth pulse.
- After init, push "A" (0x41) → one pulse carrying 0x141 two cycles after the push; `fifo_level` returns to 0.
- Push 17 characters 0x30..0x40 with COLS=16 → 16 data pulses, then 0x0C0, then 0x140.
- Push 0x0A, 0x0A, 0x0C → pulses 0x0C0, 0x080, 0x001, 0x080; col=0 and line=0 at the end.
- Hold `lcd_status`=1 and push 33 characters with DEPTH=32 → `cpu_wait` rises after 32 pushes and the 33rd is dropped. Release `lcd_status` → exactly 32 data pulses in order.
- Assert `rst` for one cycle mid-stream with 10 characters queued → the next pulse is 0x038 and no queued character is ever emitted.
